// File: rtl/proc_pkg.sv
// Shared pipeline definitions used by the machine-mode CSR unit.
//   csr_op_mode_t  : CSR operation issued by decode (none/read-write/set/clear)
//   CSR_*          : implemented CSR addresses
//   MIE_BIT/MPIE_BIT, EXC_ILLEGAL_INST
//   csr_apply      : computes the post-write value of a CSR for a given op
package proc_pkg;

  typedef enum logic [1:0] {
    CSR_NONE       = 2'd0,
    CSR_READ_WRITE = 2'd1,
    CSR_SET        = 2'd2,
    CSR_CLR        = 2'd3
  } csr_op_mode_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [3:0] EXC_ILLEGAL_INST = 4'h2;

  function automatic logic [31:0] csr_apply(csr_op_mode_t op, logic [31:0] old_v,
                                            logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_READ_WRITE: res = wdata;
      CSR_SET:        res = old_v | wdata;
      CSR_CLR:        res = old_v & ~wdata;
      default:        res = old_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Pipeline <-> CSR unit bundle: X-stage CSR request, M-stage trap/return
// events, retire strobe, and the registered read data / redirect outputs.
//   master : pipeline control side
//   slave  : csr_unit side
interface csr_unit_if;
  import proc_pkg::*;

  logic         csr_r_en_i;
  logic [11:0]  csr_addr_i;
  csr_op_mode_t csr_op_mode_i;
  logic [31:0]  csr_wdata_i;
  logic [31:0]  x_pc_i;
  logic         exception_i;
  logic [3:0]   excep_code_i;
  logic         load_mcause_i;
  logic [31:0]  epc_i;
  logic         ret_i;
  logic         instret_i;
  logic [31:0]  csr_rdata_o;
  logic         csr_exception_o;
  logic         redirect_o;
  logic [31:0]  redirect_pc_o;

  modport master (
    output csr_r_en_i, csr_addr_i, csr_op_mode_i, csr_wdata_i, x_pc_i,
           exception_i, excep_code_i, load_mcause_i, epc_i, ret_i, instret_i,
    input  csr_rdata_o, csr_exception_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  csr_r_en_i, csr_addr_i, csr_op_mode_i, csr_wdata_i, x_pc_i,
           exception_i, excep_code_i, load_mcause_i, epc_i, ret_i, instret_i,
    output csr_rdata_o, csr_exception_o, redirect_o, redirect_pc_o
  );

endinterface

// File: rtl/csr_unit_counter64.sv
// 64-bit free-running counter with independent half writes.
//   clk_i, rst_n_i : clock, async active-low reset
//   inc_en_i       : increment this cycle
//   wr_lo_i/wr_hi_i: replace the low/high half with wdata_i
//   count_o        : current count
// A write to either half takes precedence over the increment on that edge.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        inc_en_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0]  = wdata_i;
      if (wr_hi_i) count_d[63:32] = wdata_i;
    end else if (inc_en_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap responder.
//   clk_i, rst_n_i : clock, async active-low reset
//   bus (slave)    : X-stage CSR request, M-stage exception/MRET, retire strobe;
//                    returns registered old CSR value, illegal-access pulse and
//                    fetch redirect pulse/target, all one cycle after the event.
module csr_unit
  import proc_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  csr_unit_if.slave bus
);

  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] rdata_q, redirect_pc_q;
  logic        csr_exc_q, redirect_q;
  logic [63:0] mcycle, minstret;

  logic        x_req, impl, wr_req, illegal, do_write;
  logic [31:0] rd_val, new_val, mstatus_v;

  // Any M-stage event kills the younger X-stage request outright.
  assign x_req = bus.csr_r_en_i & ~bus.exception_i & ~bus.ret_i;

  always_comb begin
    mstatus_v = '0;
    mstatus_v[MIE_BIT]  = mie_q;
    mstatus_v[MPIE_BIT] = mpie_q;
  end

  always_comb begin
    impl   = 1'b1;
    rd_val = '0;
    case (bus.csr_addr_i)
      CSR_MSTATUS:                 rd_val = mstatus_v;
      CSR_MISA:                    rd_val = MISA_VAL;
      CSR_MTVEC:                   rd_val = mtvec_q;
      CSR_MSCRATCH:                rd_val = mscratch_q;
      CSR_MEPC:                    rd_val = mepc_q;
      CSR_MCAUSE:                  rd_val = mcause_q;
      CSR_MCYCLE,   CSR_CYCLE:     rd_val = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    rd_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rd_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret[63:32];
      CSR_MHARTID:                 rd_val = HART_ID;
      default:                     impl   = 1'b0;
    endcase
  end

  // csrrs/csrrc with a zero operand never writes, so it can target RO space.
  always_comb begin
    case (bus.csr_op_mode_i)
      CSR_READ_WRITE:   wr_req = 1'b1;
      CSR_SET, CSR_CLR: wr_req = (bus.csr_wdata_i != 32'd0);
      default:          wr_req = 1'b0;
    endcase
  end

  assign illegal  = x_req & (~impl | (wr_req & (bus.csr_addr_i[11:10] == 2'b11)));
  assign do_write = x_req & wr_req & ~illegal;
  assign new_val  = csr_apply(bus.csr_op_mode_i, rd_val, bus.csr_wdata_i);

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (bus.exception_i) begin
      mepc_d = {bus.epc_i[31:2], 2'b00};
      if (bus.load_mcause_i) mcause_d = {28'd0, bus.excep_code_i};
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (bus.ret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (illegal) begin
      mepc_d   = {bus.x_pc_i[31:2], 2'b00};
      mcause_d = {28'd0, EXC_ILLEGAL_INST};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (do_write) begin
      case (bus.csr_addr_i)
        CSR_MSTATUS: begin
          mie_d  = new_val[MIE_BIT];
          mpie_d = new_val[MPIE_BIT];
        end
        CSR_MTVEC:    mtvec_d    = {new_val[31:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = {new_val[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = new_val;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .inc_en_i (1'b1),
    .wr_lo_i  (do_write & (bus.csr_addr_i == CSR_MCYCLE)),
    .wr_hi_i  (do_write & (bus.csr_addr_i == CSR_MCYCLEH)),
    .wdata_i  (new_val),
    .count_o  (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .inc_en_i (bus.instret_i),
    .wr_lo_i  (do_write & (bus.csr_addr_i == CSR_MINSTRET)),
    .wr_hi_i  (do_write & (bus.csr_addr_i == CSR_MINSTRETH)),
    .wdata_i  (new_val),
    .count_o  (minstret)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      rdata_q       <= '0;
      csr_exc_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      if (bus.csr_r_en_i) rdata_q <= rd_val;
      csr_exc_q  <= illegal;
      redirect_q <= bus.exception_i | bus.ret_i | illegal;
      // Targets use the pre-edge mtvec/mepc; a squashed mtvec write can't leak in.
      if (bus.exception_i || illegal) redirect_pc_q <= mtvec_q;
      else if (bus.ret_i)             redirect_pc_q <= mepc_q;
    end
  end

  assign bus.csr_rdata_o     = rdata_q;
  assign bus.csr_exception_o = csr_exc_q;
  assign bus.redirect_o      = redirect_q;
  assign bus.redirect_pc_o   = redirect_pc_q;

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  csr_unit_if bus_if();

  csr_unit dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       nm;
    bit          chk_rd;
    logic [31:0] rd;
    bit          exc;
    bit          redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: compares the DUT outputs against whatever is due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: stale expectation due %0d at cycle %0d", e.nm, e.due, cyc);
      end else begin
        if (e.chk_rd) chk({e.nm, " rdata"}, bus_if.csr_rdata_o, e.rd);
        chk({e.nm, " csr_exc"}, {31'd0, bus_if.csr_exception_o}, {31'd0, e.exc});
        chk({e.nm, " redirect"}, {31'd0, bus_if.redirect_o}, {31'd0, e.redir});
        if (e.redir) chk({e.nm, " redirect_pc"}, bus_if.redirect_pc_o, e.rpc);
      end
    end
  end

  task automatic idle();
    bus_if.csr_r_en_i    = 1'b0;
    bus_if.csr_addr_i    = '0;
    bus_if.csr_op_mode_i = CSR_NONE;
    bus_if.csr_wdata_i   = '0;
    bus_if.x_pc_i        = '0;
    bus_if.exception_i   = 1'b0;
    bus_if.excep_code_i  = '0;
    bus_if.load_mcause_i = 1'b0;
    bus_if.epc_i         = '0;
    bus_if.ret_i         = 1'b0;
    bus_if.instret_i     = 1'b0;
  endtask

  task automatic req(logic [11:0] a, csr_op_mode_t m, logic [31:0] wd, logic [31:0] pc);
    bus_if.csr_r_en_i    = 1'b1;
    bus_if.csr_addr_i    = a;
    bus_if.csr_op_mode_i = m;
    bus_if.csr_wdata_i   = wd;
    bus_if.x_pc_i        = pc;
  endtask

  task automatic exc(logic [3:0] code, bit ld, logic [31:0] epc);
    bus_if.exception_i   = 1'b1;
    bus_if.excep_code_i  = code;
    bus_if.load_mcause_i = ld;
    bus_if.epc_i         = epc;
  endtask

  // Push the response expected one cycle later, clock the current inputs, go idle.
  task automatic go(string nm, bit chk_rd, logic [31:0] rd, bit e, bit r, logic [31:0] rpc);
    exp_t x;
    x.due = cyc + 1; x.nm = nm; x.chk_rd = chk_rd; x.rd = rd;
    x.exc = e; x.redir = r; x.rpc = rpc;
    sb.push_back(x);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rd(string nm, logic [11:0] a, logic [31:0] want);
    req(a, CSR_NONE, 32'd0, 32'd0);
    go(nm, 1'b1, want, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    idle();
    #12;
    chk("reset rdata", bus_if.csr_rdata_o, 32'd0);
    chk("reset csr_exc", {31'd0, bus_if.csr_exception_o}, 32'd0);
    chk("reset redirect", {31'd0, bus_if.redirect_o}, 32'd0);
    chk("reset redirect_pc", bus_if.redirect_pc_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    req(CSR_MTVEC, CSR_SET, 32'd0, 32'h10);
    go("csrrs mtvec", 1'b1, 32'h0000_0100, 1'b0, 1'b0, 0);
    req(CSR_MSCRATCH, CSR_READ_WRITE, 32'hDEAD_BEEF, 32'h14);
    go("csrrw mscratch", 1'b1, 32'h0, 1'b0, 1'b0, 0);
    req(CSR_MSCRATCH, CSR_CLR, 32'h0000_00FF, 32'h18);
    go("csrrc mscratch", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    rd("mscratch after clr", CSR_MSCRATCH, 32'hDEAD_BE00);

    req(CSR_CYCLE, CSR_READ_WRITE, 32'd5, 32'h200);
    go("csrrw cycle RO", 1'b0, 0, 1'b1, 1'b1, 32'h100);
    rd("mcause illegal", CSR_MCAUSE, 32'd2);
    rd("mepc illegal", CSR_MEPC, 32'h200);
    req(CSR_CYCLE, CSR_SET, 32'd0, 32'h204);
    go("csrrs cycle x0", 1'b0, 0, 1'b0, 1'b0, 0);
    req(12'h7C0, CSR_NONE, 32'd0, 32'h300);
    go("unimpl addr", 1'b0, 0, 1'b1, 1'b1, 32'h100);
    rd("mepc unimpl", CSR_MEPC, 32'h300);

    req(CSR_MSTATUS, CSR_SET, 32'h8, 32'h20);
    go("set MIE", 1'b1, 32'h0, 1'b0, 1'b0, 0);
    rd("mstatus MIE", CSR_MSTATUS, 32'h8);
    exc(4'hB, 1'b1, 32'h40);
    go("exception B", 1'b0, 0, 1'b0, 1'b1, 32'h100);
    rd("mcause B", CSR_MCAUSE, 32'hB);
    rd("mepc 40", CSR_MEPC, 32'h40);
    rd("mstatus trap", CSR_MSTATUS, 32'h80);
    bus_if.ret_i = 1'b1;
    go("mret", 1'b0, 0, 1'b0, 1'b1, 32'h40);
    rd("mstatus mret", CSR_MSTATUS, 32'h88);

    exc(4'h7, 1'b0, 32'h44);
    req(CSR_MTVEC, CSR_READ_WRITE, 32'h800, 32'h24);
    go("exc+mtvec write", 1'b0, 0, 1'b0, 1'b1, 32'h100);
    rd("mtvec unchanged", CSR_MTVEC, 32'h100);
    rd("mcause kept", CSR_MCAUSE, 32'hB);
    rd("mepc 44", CSR_MEPC, 32'h44);

    req(CSR_MTVEC, CSR_READ_WRITE, 32'h203, 32'h28);
    go("csrrw mtvec", 1'b1, 32'h100, 1'b0, 1'b0, 0);
    rd("mtvec aligned", CSR_MTVEC, 32'h200);
    req(CSR_MEPC, CSR_READ_WRITE, 32'h47, 32'h2C);
    go("csrrw mepc", 1'b1, 32'h44, 1'b0, 1'b0, 0);
    rd("mepc aligned", CSR_MEPC, 32'h44);
    req(CSR_MISA, CSR_READ_WRITE, 32'h0, 32'h30);
    go("csrrw misa", 1'b1, 32'h4000_0100, 1'b0, 1'b0, 0);
    rd("misa kept", CSR_MISA, 32'h4000_0100);
    rd("mhartid", CSR_MHARTID, 32'h0);
    req(CSR_MSTATUS, CSR_READ_WRITE, 32'hFFFF_FFFF, 32'h34);
    go("csrrw mstatus", 1'b1, 32'h80, 1'b0, 1'b0, 0);
    rd("mstatus mask", CSR_MSTATUS, 32'h88);

    req(CSR_MCYCLE, CSR_READ_WRITE, 32'hFFFF_FFFF, 32'h38);
    go("write mcycle lo", 1'b0, 0, 1'b0, 1'b0, 0);
    rd("mcycleh pre-carry", CSR_MCYCLEH, 32'd0);
    rd("mcycleh carry", CSR_MCYCLEH, 32'd1);
    rd("cycleh shadow", CSR_CYCLEH, 32'd1);

    req(CSR_MINSTRET, CSR_READ_WRITE, 32'd10, 32'h3C);
    bus_if.instret_i = 1'b1;
    go("write minstret", 1'b0, 0, 1'b0, 1'b0, 0);
    req(CSR_MINSTRET, CSR_NONE, 32'd0, 32'h40);
    bus_if.instret_i = 1'b1;
    go("minstret 10", 1'b1, 32'd10, 1'b0, 1'b0, 0);
    rd("instret shadow", CSR_INSTRET, 32'd11);
    req(CSR_MINSTRET, CSR_READ_WRITE, 32'hFFFF_FFFF, 32'h44);
    go("write minstret max", 1'b0, 0, 1'b0, 1'b0, 0);
    bus_if.instret_i = 1'b1;
    req(CSR_MINSTRETH, CSR_NONE, 32'd0, 32'h48);
    go("minstreth pre", 1'b1, 32'd0, 1'b0, 1'b0, 0);
    rd("minstreth carry", CSR_MINSTRETH, 32'd1);

    exc(4'h3, 1'b1, 32'h60);
    bus_if.ret_i = 1'b1;
    go("exc beats mret", 1'b0, 0, 1'b0, 1'b1, 32'h200);
    rd("mepc 60", CSR_MEPC, 32'h60);
    rd("mcause 3", CSR_MCAUSE, 32'h3);
    bus_if.ret_i = 1'b1;
    req(CSR_MSCRATCH, CSR_READ_WRITE, 32'h1234, 32'h4C);
    go("mret squashes csr", 1'b0, 0, 1'b0, 1'b1, 32'h60);
    rd("mscratch kept", CSR_MSCRATCH, 32'hDEAD_BE00);
    req(CSR_MHARTID, CSR_READ_WRITE, 32'h1, 32'h50);
    go("write mhartid", 1'b0, 0, 1'b1, 1'b1, 32'h200);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    #1;
    exc(4'h1, 1'b1, 32'h70);
    @(posedge clk); #1;
    idle();
    chk("pulse before reset", {31'd0, bus_if.redirect_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset clears redirect", {31'd0, bus_if.redirect_o}, 32'd0);
    chk("reset clears pc", bus_if.redirect_pc_o, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rd("mscratch after reset", CSR_MSCRATCH, 32'd0);
    rd("mtvec after reset", CSR_MTVEC, 32'h100);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
